// File: rtl/vx_sau_operand_feeder.sv
// vx_sau_operand_feeder: skews an N x N operand pair into the systolic array, drains it, then reports a tagged completion.
// Optional SAU_FEED_PERF_EN adds perf_busy_cycles / perf_ops counters.
module vx_sau_operand_feeder #(
   parameter int MATRIX_SIZE  = 2,
   parameter int DATA_SIZE    = 32,
   parameter int TAG_WIDTH    = 8,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] in_a,
   input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] in_b,
   input  logic [TAG_WIDTH-1:0]                      in_tag,
   output logic [MATRIX_SIZE*DATA_SIZE-1:0]          feed_a,
   output logic [MATRIX_SIZE*DATA_SIZE-1:0]          feed_b,
   output logic                                      feed_valid,
   output logic                                      feed_clear,
   output logic                                      done_valid,
   output logic [TAG_WIDTH-1:0]                      done_tag,
`ifdef SAU_FEED_PERF_EN
   output logic [43:0]                               perf_busy_cycles,
   output logic [43:0]                               perf_ops,
`endif
   input  logic                                      done_ready
);
   localparam int N = MATRIX_SIZE;
   localparam int W = DATA_SIZE;
   localparam int FEED_STEPS = 2*N-1;
   localparam int CW = $clog2(FEED_STEPS > DRAIN_CYCLES ? FEED_STEPS : DRAIN_CYCLES) + 1;

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

   state_t                 state;
   logic [CW-1:0]          t;
   logic [N*N*W-1:0]       a_q, b_q;
   logic [TAG_WIDTH-1:0]   tag_q;

   // Diagonal skew step t: lane i gets A[i][t-i] (rows) or B[t-i][i] (columns), zero outside the matrix.
   function automatic logic [N*W-1:0] skew(input logic [N*N*W-1:0] m, input int step, input logic col);
      skew = '0;
      for (int i = 0; i < N; i++)
         if (step - i >= 0 && step - i < N)
            skew[i*W +: W] = col ? m[((step-i)*N+i)*W +: W] : m[(i*N+step-i)*W +: W];
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         feed_a     <= '0;
         feed_b     <= '0;
         feed_valid <= 1'b0;
         feed_clear <= 1'b0;
         done_valid <= 1'b0;
         done_tag   <= '0;
         t          <= '0;
         a_q        <= '0;
         b_q        <= '0;
         tag_q      <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q        <= in_a;
               b_q        <= in_b;
               tag_q      <= in_tag;
               in_ready   <= 1'b0;
               feed_clear <= 1'b1;
               state      <= CLEAR;
            end
            CLEAR: begin
               feed_clear <= 1'b0;
               feed_valid <= 1'b1;
               feed_a     <= skew(a_q, 0, 1'b0);
               feed_b     <= skew(b_q, 0, 1'b1);
               t          <= '0;
               state      <= FEED;
            end
            FEED: if (t == CW'(2*N-2)) begin
               feed_valid <= 1'b0;
               feed_a     <= '0;
               feed_b     <= '0;
               t          <= '0;
               state      <= DRAIN;
            end else begin
               feed_a <= skew(a_q, int'(t) + 1, 1'b0);
               feed_b <= skew(b_q, int'(t) + 1, 1'b1);
               t      <= t + 1'b1;
            end
            DRAIN: if (t == CW'(DRAIN_CYCLES-1)) begin
               done_valid <= 1'b1;
               done_tag   <= tag_q;
               state      <= DONE;
            end else begin
               t <= t + 1'b1;
            end
            DONE: if (done_ready) begin
               done_valid <= 1'b0;
               done_tag   <= '0;
               in_ready   <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SAU_FEED_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_busy_cycles <= '0;
         perf_ops         <= '0;
      end else begin
         if (state != IDLE)
            perf_busy_cycles <= perf_busy_cycles + 44'd1;
         if (done_valid && done_ready)
            perf_ops <= perf_ops + 44'd1;
      end
   end
`endif
endmodule
